// File: rtl/sdes_pkg.sv
// Shared S-DES constants, state codes and bit-permutation helpers.
// Bit 0 is the leftmost (MSB) bit of every vector, matching the S-DES literature.
package sdes_pkg;

    localparam int unsigned SUBKEY_W = 8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Indexed by {row, col} = {x[0], x[3], x[1], x[2]}
    localparam logic [1:0] S0 [16] = '{
        2'd1, 2'd0, 2'd3, 2'd2,
        2'd3, 2'd2, 2'd1, 2'd0,
        2'd0, 2'd2, 2'd1, 2'd3,
        2'd3, 2'd1, 2'd3, 2'd2
    };

    localparam logic [1:0] S1 [16] = '{
        2'd0, 2'd1, 2'd2, 2'd3,
        2'd2, 2'd0, 2'd1, 2'd3,
        2'd3, 2'd0, 2'd1, 2'd0,
        2'd2, 2'd1, 2'd0, 2'd3
    };

    function automatic logic [0:7] ep(input logic [0:3] r);
        return {r[3], r[0], r[1], r[2], r[1], r[2], r[3], r[0]};
    endfunction

    function automatic logic [0:3] p4(input logic [0:3] p);
        return {p[1], p[3], p[2], p[0]};
    endfunction

    function automatic logic [0:7] ip(input logic [0:7] x);
        return {x[1], x[5], x[2], x[0], x[3], x[7], x[4], x[6]};
    endfunction

    function automatic logic [0:7] ip_inv(input logic [0:7] x);
        return {x[3], x[0], x[2], x[4], x[6], x[1], x[7], x[5]};
    endfunction

endpackage

// File: rtl/sdes_round_f.sv
// Combinational S-DES round function F(R, K): expand, key-mix, S-boxes, P4.
module sdes_round_f
    import sdes_pkg::*;
(
    input  logic [0:3]          i_r,
    input  logic [0:SUBKEY_W-1] i_k,
    output logic [0:3]          o_f
);

    logic [0:7] w_x;
    logic [0:3] w_p;

    assign w_x = ep(i_r) ^ i_k;
    assign w_p = {S0[{w_x[0], w_x[3], w_x[1], w_x[2]}], S1[{w_x[4], w_x[7], w_x[5], w_x[6]}]};
    assign o_f = p4(w_p);

endmodule

// File: rtl/sdes_feistel_engine.sv
// Iterative S-DES Feistel engine: one round per clock, valid/ready in and out.
module sdes_feistel_engine
    import sdes_pkg::*;
#(
    parameter int unsigned ROUNDS = 2,
    parameter bit          USE_IP = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_decrypt,
    input  logic [0:7]                   in_block,
    input  logic [0:SUBKEY_W*ROUNDS-1]   in_keys,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [0:7]                   out_block
);

    localparam int unsigned      CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(ROUNDS - 1);

    state_t                      r_state;
    logic [0:3]                  r_l;
    logic [0:3]                  r_r;
    logic [0:SUBKEY_W*ROUNDS-1]  r_keys;
    logic                        r_decrypt;
    logic [CNT_W-1:0]            r_cnt;
    logic                        r_out_valid;
    logic [0:7]                  r_out_block;

    logic [CNT_W-1:0]            w_kidx;
    logic [0:SUBKEY_W-1]         w_key;
    logic [0:7]                  w_x_in;
    logic [0:3]                  w_f;
    logic [0:3]                  w_l_next;
    logic                        w_accept;

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out_block = r_out_block;

    // Decryption walks the latched subkeys in reverse order.
    assign w_kidx   = r_decrypt ? (LAST - r_cnt) : r_cnt;
    assign w_key    = r_keys[SUBKEY_W*w_kidx +: SUBKEY_W];
    assign w_x_in   = USE_IP ? ip(in_block) : in_block;
    assign w_l_next = r_l ^ w_f;

    sdes_round_f u_round_f (
        .i_r (r_r),
        .i_k (w_key),
        .o_f (w_f)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_l         <= '0;
            r_r         <= '0;
            r_keys      <= '0;
            r_decrypt   <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_block <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_l       <= w_x_in[0:3];
                        r_r       <= w_x_in[4:7];
                        r_keys    <= in_keys;
                        r_decrypt <= in_decrypt;
                        r_cnt     <= '0;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == LAST) begin
                        // Final round: no swap, result goes straight to the output register.
                        r_out_block <= USE_IP ? ip_inv({w_l_next, r_r}) : {w_l_next, r_r};
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_l   <= r_r;
                        r_r   <= w_l_next;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdes_feistel_engine.sv
// Bench for sdes_feistel_engine: three configurations checked against an S-DES model.
module tb_sdes_feistel_engine;

    localparam int IPT  [8] = '{1, 5, 2, 0, 3, 7, 4, 6};
    localparam int IPIT [8] = '{3, 0, 2, 4, 6, 1, 7, 5};
    localparam int EPT  [8] = '{3, 0, 1, 2, 1, 2, 3, 0};
    localparam int P4T  [4] = '{1, 3, 2, 0};
    localparam int S0T  [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
    localparam int S1T  [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

    logic        clk = 1'b0;
    logic        rst;
    logic        in_decrypt;
    logic [0:7]  in_block;
    logic [0:31] keys;
    logic        out_ready;
    logic        iv_a, iv_b, iv_c;
    logic        ir_a, ir_b, ir_c;
    logic        ov_a, ov_b, ov_c;
    logic [0:7]  ob_a, ob_b, ob_c;

    int          checks = 0;
    int          errors = 0;
    logic [0:7]  res, ct, pt, blk;
    int          lat;

    always #5 clk = ~clk;

    sdes_feistel_engine #(.ROUNDS(2), .USE_IP(1'b1)) u_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .in_decrypt(in_decrypt),
        .in_block(in_block), .in_keys(keys[0:15]), .out_valid(ov_a), .out_ready(out_ready),
        .out_block(ob_a)
    );

    sdes_feistel_engine #(.ROUNDS(4), .USE_IP(1'b0)) u_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .in_decrypt(in_decrypt),
        .in_block(in_block), .in_keys(keys[0:31]), .out_valid(ov_b), .out_ready(out_ready),
        .out_block(ob_b)
    );

    sdes_feistel_engine #(.ROUNDS(1), .USE_IP(1'b1)) u_c (
        .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(ir_c), .in_decrypt(in_decrypt),
        .in_block(in_block), .in_keys(keys[0:7]), .out_valid(ov_c), .out_ready(out_ready),
        .out_block(ob_c)
    );

    // Textbook S-DES, generalised to n rounds with a swap between rounds.
    function automatic logic [0:7] model(input logic [0:7] b, input logic [0:31] k, input int n,
                                         input bit use_ip, input bit dec);
        logic [0:7] x, e, y;
        logic [0:3] l, r, f, p, t;
        int ki, v0, v1;
        x = b;
        if (use_ip) for (int i = 0; i < 8; i++) x[i] = b[IPT[i]];
        l = x[0:3];
        r = x[4:7];
        for (int rd = 0; rd < n; rd++) begin
            ki = dec ? n - 1 - rd : rd;
            for (int i = 0; i < 8; i++) e[i] = r[EPT[i]] ^ k[8 * ki + i];
            v0 = S0T[2 * int'(e[0]) + int'(e[3])][2 * int'(e[1]) + int'(e[2])];
            v1 = S1T[2 * int'(e[4]) + int'(e[7])][2 * int'(e[5]) + int'(e[6])];
            p = {v0[1], v0[0], v1[1], v1[0]};
            for (int i = 0; i < 4; i++) f[i] = p[P4T[i]];
            l = l ^ f;
            if (rd < n - 1) begin
                t = l;
                l = r;
                r = t;
            end
        end
        x = {l, r};
        y = x;
        if (use_ip) for (int i = 0; i < 8; i++) y[i] = x[IPIT[i]];
        return y;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ir(input int s);
        case (s)
            0: return ir_a;
            1: return ir_b;
            default: return ir_c;
        endcase
    endfunction

    function automatic logic get_ov(input int s);
        case (s)
            0: return ov_a;
            1: return ov_b;
            default: return ov_c;
        endcase
    endfunction

    function automatic logic [0:7] get_ob(input int s);
        case (s)
            0: return ob_a;
            1: return ob_b;
            default: return ob_c;
        endcase
    endfunction

    function automatic int rounds_of(input int s);
        case (s)
            0: return 2;
            1: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic bit useip_of(input int s);
        return (s != 1);
    endfunction

    task automatic set_valid(input int s, input logic v);
        case (s)
            0: iv_a = v;
            1: iv_b = v;
            default: iv_c = v;
        endcase
    endtask

    // Called at a falling edge with the engine idle; returns at the falling edge after accept.
    task automatic accept(input int s, input logic dec, input logic [0:7] b);
        check("ready_before_accept", 32'(get_ir(s)), 32'd1);
        in_decrypt = dec;
        in_block   = b;
        set_valid(s, 1'b1);
        @(negedge clk);
        set_valid(s, 1'b0);
    endtask

    task automatic wait_result(input int s, output logic [0:7] r, output int l);
        l = 0;
        while (!get_ov(s) && l < 20) begin
            @(negedge clk);
            l++;
        end
        check("out_valid_seen", 32'(get_ov(s)), 32'd1);
        check("latency", 32'(l), 32'(rounds_of(s)));
        r = get_ob(s);
    endtask

    task automatic drain(input int s);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_valid_low", 32'(get_ov(s)), 32'd0);
        check("drain_ready_high", 32'(get_ir(s)), 32'd1);
    endtask

    task automatic run(input int s, input logic dec, input logic [0:7] b, output logic [0:7] r);
        int l;
        accept(s, dec, b);
        wait_result(s, r, l);
        drain(s);
    endtask

    initial begin
        rst        = 1'b1;
        iv_a       = 1'b0;
        iv_b       = 1'b0;
        iv_c       = 1'b0;
        out_ready  = 1'b0;
        in_decrypt = 1'b0;
        in_block   = '0;
        keys       = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(ir_a), 32'd0);
        check("rst_out_valid", 32'(ov_a), 32'd0);
        check("rst_out_block", 32'(ob_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready_a", 32'(ir_a), 32'd1);
        check("post_rst_ready_b", 32'(ir_b), 32'd1);
        check("post_rst_ready_c", 32'(ir_c), 32'd1);

        keys = {8'b10100100, 8'b01000011, 16'h0000};
        run(0, 1'b0, 8'b10010111, res);
        check("stallings_enc", 32'(res), 32'(8'b00111000));
        check("stallings_enc_model", 32'(res), 32'(model(8'b10010111, keys, 2, 1'b1, 1'b0)));
        run(0, 1'b1, 8'b00111000, res);
        check("stallings_dec", 32'(res), 32'(8'b10010111));

        // Backpressure with a competing in_valid held high
        accept(0, 1'b0, 8'b10010111);
        wait_result(0, res, lat);
        iv_a     = 1'b1;
        in_block = 8'h5a;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(ov_a), 32'd1);
            check("bp_block", 32'(ob_a), 32'(8'b00111000));
            check("bp_ready", 32'(ir_a), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        iv_a      = 1'b0;
        check("bp_drain_valid", 32'(ov_a), 32'd0);
        check("bp_drain_ready", 32'(ir_a), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("bp_no_phantom", 32'(ov_a), 32'd0);
            @(negedge clk);
        end

        // Inputs change right after acceptance
        accept(0, 1'b0, 8'b10010111);
        keys       = 32'hdeadbeef;
        in_decrypt = 1'b1;
        in_block   = 8'h00;
        wait_result(0, res, lat);
        check("latched_keys_mode", 32'(res), 32'(8'b00111000));
        drain(0);
        keys = {8'b10100100, 8'b01000011, 16'h0000};

        // Reset during RUN discards the block
        accept(0, 1'b0, 8'b10010111);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_rst_valid", 32'(ov_a), 32'd0);
        check("midrun_rst_block", 32'(ob_a), 32'd0);
        check("midrun_rst_ready", 32'(ir_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrun_post_ready", 32'(ir_a), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("midrun_no_valid", 32'(ov_a), 32'd0);
            check("midrun_block_zero", 32'(ob_a), 32'd0);
            @(negedge clk);
        end
        run(0, 1'b0, 8'b10010111, res);
        check("post_rst_stallings", 32'(res), 32'(8'b00111000));

        // Random round trips on the 4-round and 1-round engines
        for (int s = 1; s < 3; s++) begin
            for (int i = 0; i < 100; i++) begin
                blk  = 8'($urandom);
                keys = $urandom;
                run(s, 1'b0, blk, ct);
                check("rand_enc", 32'(ct), 32'(model(blk, keys, rounds_of(s), useip_of(s), 1'b0)));
                run(s, 1'b1, ct, pt);
                check("rand_roundtrip", 32'(pt), 32'(blk));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
